// File: rtl/elevator_pkg.sv
// Shared elevator definitions.
//   - state_t      : car controller FSM states
//   - FLOOR_COUNT_DEFAULT : default number of floors
//   - onehot()     : floor index -> one-hot floor vector (wide; callers
//                    truncate to their own FLOOR_COUNT)
package elevator_pkg;

   localparam int unsigned FLOOR_COUNT_DEFAULT = 8;
   localparam int unsigned MAX_FLOORS          = 64;

   typedef logic [MAX_FLOORS-1:0] floor_vec_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MOVE,
      ST_ARRIVE,
      ST_DOOR
   } state_t;

   function automatic floor_vec_t onehot(input int unsigned floor);
      return floor_vec_t'(1) << floor;
   endfunction

endpackage

// File: rtl/elevator_request_scan.sv
// Classifies pending floor requests relative to a floor index.
// Ports:
//   queue_rd_i  in  FLOOR_COUNT  request bitmap, bit i = floor i
//   floor_i     in  FW           reference floor
//   here_o      out 1            request at floor_i
//   above_o     out 1            any request above floor_i
//   below_o     out 1            any request below floor_i
module elevator_request_scan
   import elevator_pkg::*;
#(
   parameter int unsigned FLOOR_COUNT = FLOOR_COUNT_DEFAULT,
   parameter int unsigned FW          = $clog2(FLOOR_COUNT)
) (
   input  logic [FLOOR_COUNT-1:0] queue_rd_i,
   input  logic [FW-1:0]          floor_i,
   output logic                   here_o,
   output logic                   above_o,
   output logic                   below_o
);

   logic [FLOOR_COUNT-1:0] at_mask;
   logic [FLOOR_COUNT-1:0] below_mask;
   logic [FLOOR_COUNT-1:0] above_mask;

   // Everything strictly below the one-hot floor bit is (at_mask - 1);
   // what is neither at nor below is above.
   assign at_mask    = FLOOR_COUNT'(1) << floor_i;
   assign below_mask = at_mask - 1'b1;
   assign above_mask = ~(at_mask | below_mask);

   assign here_o  = |(queue_rd_i & at_mask);
   assign above_o = |(queue_rd_i & above_mask);
   assign below_o = |(queue_rd_i & below_mask);

endmodule

// File: rtl/elevator_car_controller.sv
// Single-car elevator controller with SCAN stop selection.
// Reads the request queue bitmap, moves the car floor by floor, opens the
// door on arrival and writes a one-cycle clear back to the queue.
// Ports:
//   clk            in  1            clock
//   reset          in  1            synchronous, active-high
//   queue_rd       in  FLOOR_COUNT  queue contents (valid while queue_r_nwr=1)
//   queue_r_nwr    out 1            1 = read queue, 0 = write this cycle
//   queue_clear    out 1            clear request (with queue_r_nwr=0)
//   queue_wr       out FLOOR_COUNT  one-hot floor to clear
//   current_floor  out FW           floor the car is at / last passed
//   moving_up      out 1            motor up
//   moving_down    out 1            motor down
//   door_open      out 1            door command
//   idle           out 1            controller idle
module elevator_car_controller
   import elevator_pkg::*;
#(
   parameter  int unsigned FLOOR_COUNT   = FLOOR_COUNT_DEFAULT,
   parameter  int unsigned TRAVEL_CYCLES = 8,
   parameter  int unsigned DOOR_CYCLES   = 16,
   localparam int unsigned FW            = $clog2(FLOOR_COUNT)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [FLOOR_COUNT-1:0] queue_rd,
   output logic                   queue_r_nwr,
   output logic                   queue_clear,
   output logic [FLOOR_COUNT-1:0] queue_wr,
   output logic [FW-1:0]          current_floor,
   output logic                   moving_up,
   output logic                   moving_down,
   output logic                   door_open,
   output logic                   idle
);

   localparam int unsigned TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
   localparam int unsigned DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
   localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
   localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYCLES - 1);

   state_t        state_q, state_d;
   logic          dir_q, dir_d;
   logic [FW-1:0] floor_q, floor_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [DW-1:0] dcnt_q, dcnt_d;

   logic [FW-1:0] floor_eval;
   logic          here, above, below;
   logic          ahead, behind;
   logic          eval;

   // The scan looks at the floor the car will occupy after this edge, so a
   // terminal travel count decides against the newly reached floor.
   always_comb begin
      floor_eval = floor_q;
      if (state_q == ST_MOVE && tcnt_q == TRAVEL_LAST) begin
         floor_eval = dir_q ? floor_q + 1'b1 : floor_q - 1'b1;
      end
   end

   elevator_request_scan #(
      .FLOOR_COUNT (FLOOR_COUNT),
      .FW          (FW)
   ) u_scan (
      .queue_rd_i (queue_rd),
      .floor_i    (floor_eval),
      .here_o     (here),
      .above_o    (above),
      .below_o    (below)
   );

   assign ahead  = dir_q ? above : below;
   assign behind = dir_q ? below : above;

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      floor_d = floor_q;
      tcnt_d  = tcnt_q;
      dcnt_d  = dcnt_q;
      eval    = 1'b0;

      case (state_q)
         ST_IDLE: eval = 1'b1;
         ST_MOVE: begin
            if (tcnt_q == TRAVEL_LAST) begin
               tcnt_d  = '0;
               floor_d = floor_eval;
               eval    = 1'b1;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         ST_ARRIVE: begin
            state_d = ST_DOOR;
            dcnt_d  = '0;
         end
         ST_DOOR: begin
            if (dcnt_q == DOOR_LAST) begin
               state_d = ST_IDLE;
               dcnt_d  = '0;
            end else begin
               dcnt_d = dcnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Shared SCAN decision for IDLE and for each floor reached in MOVE.
      if (eval) begin
         if (here) begin
            state_d = ST_ARRIVE;
         end else if (ahead) begin
            state_d = ST_MOVE;
         end else if (behind) begin
            dir_d   = ~dir_q;
            state_d = ST_MOVE;
         end else begin
            state_d = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         dir_q   <= 1'b1;
         floor_q <= '0;
         tcnt_q  <= '0;
         dcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         floor_q <= floor_d;
         tcnt_q  <= tcnt_d;
         dcnt_q  <= dcnt_d;
      end
   end

   always_comb begin
      queue_r_nwr   = 1'b1;
      queue_clear   = 1'b0;
      queue_wr      = '0;
      current_floor = floor_q;
      moving_up     = (state_q == ST_MOVE) &&  dir_q;
      moving_down   = (state_q == ST_MOVE) && !dir_q;
      door_open     = (state_q == ST_DOOR);
      idle          = (state_q == ST_IDLE);
      if (state_q == ST_ARRIVE) begin
         queue_r_nwr = 1'b0;
         queue_clear = 1'b1;
         queue_wr    = FLOOR_COUNT'(onehot(32'(floor_q)));
      end
   end

endmodule

// File: tb/tb_elevator_car_controller.sv
module tb_elevator_car_controller;

   localparam int unsigned NF = 8;
   localparam int unsigned T  = 8;
   localparam int unsigned D  = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [NF-1:0] queue_rd;
   logic          queue_r_nwr;
   logic          queue_clear;
   logic [NF-1:0] queue_wr;
   logic [2:0]    current_floor;
   logic          moving_up;
   logic          moving_down;
   logic          door_open;
   logic          idle;

   always #5 clk = ~clk;

   elevator_car_controller #(
      .FLOOR_COUNT   (NF),
      .TRAVEL_CYCLES (T),
      .DOOR_CYCLES   (D)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .queue_rd      (queue_rd),
      .queue_r_nwr   (queue_r_nwr),
      .queue_clear   (queue_clear),
      .queue_wr      (queue_wr),
      .current_floor (current_floor),
      .moving_up     (moving_up),
      .moving_down   (moving_down),
      .door_open     (door_open),
      .idle          (idle)
   );

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned cyc   = 0;
   int unsigned both_err = 0;

   // Bench-side request queue: clears land on the edge that ends ARRIVE.
   logic [NF-1:0] qbits;
   logic          clr_pend;
   logic [NF-1:0] clr_mask;

   typedef struct {
      logic [NF-1:0] req;
      logic [2:0]    floor;
      logic [NF-1:0] wr;
      int unsigned   ups;
      int unsigned   downs;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (clr_pend) begin
         qbits    = qbits & ~clr_mask;
         clr_pend = 1'b0;
      end
      queue_rd = qbits;
      if (!queue_r_nwr && queue_clear) begin
         clr_pend = 1'b1;
         clr_mask = queue_wr;
      end
      if (moving_up && moving_down) both_err++;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      qbits    = '0;
      queue_rd = '0;
      clr_pend = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic run_stop(input int unsigned budget, output int unsigned lat,
                           output int unsigned ups, output int unsigned downs,
                           output logic [NF-1:0] wr, output logic [2:0] flr,
                           output logic got);
      lat = 0; ups = 0; downs = 0; wr = '0; flr = '0; got = 1'b0;
      while (lat < budget && !got) begin
         step();
         lat++;
         if (!queue_r_nwr) begin
            got = 1'b1;
            wr  = queue_wr;
            flr = current_floor;
         end else begin
            if (moving_up)   ups++;
            if (moving_down) downs++;
         end
      end
   endtask

   task automatic run_door(output int unsigned n, output logic idle_after);
      logic done;
      n = 0; idle_after = 1'b0; done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         step();
         if (door_open) n++;
         else begin
            done       = 1'b1;
            idle_after = idle;
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int unsigned   lat, ups, downs, dn, bad, t, t0, tend, n;
      logic [NF-1:0] wr, bits, b;
      logic [2:0]    flr;
      logic          got, idl, done, md, first, found;
      int            mf, nxt, j;
      int unsigned   exp_cyc[$], got_cyc[$];
      logic [NF-1:0] exp_wr[$], got_wr[$];
      logic [2:0]    exp_fl[$], got_fl[$];

      vecs[0] = '{8'h08, 3'd3, 8'h08, 24, 0};
      vecs[1] = '{8'h80, 3'd7, 8'h80, 32, 0};
      vecs[2] = '{8'h01, 3'd0, 8'h01, 0, 56};
      vecs[3] = '{8'h01, 3'd0, 8'h01, 0, 0};
      vecs[4] = '{8'h20, 3'd5, 8'h20, 40, 0};
      vecs[5] = '{8'h10, 3'd4, 8'h10, 0, 8};

      // Reset values, then 50 quiet cycles.
      do_reset();
      check("reset_outputs",
            64'({idle, current_floor, moving_up, moving_down, door_open, queue_r_nwr, queue_clear, queue_wr}),
            64'({1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00}));
      bad = 0;
      repeat (50) begin
         step();
         if (!idle || current_floor != 3'd0 || moving_up || moving_down || door_open ||
             !queue_r_nwr || queue_clear) bad++;
      end
      check("reset_idle50", 64'(bad), 64'(0));

      // Single-request trips chained from the reset position.
      foreach (vecs[i]) begin
         qbits    = vecs[i].req;
         queue_rd = qbits;
         run_stop(200, lat, ups, downs, wr, flr, got);
         check($sformatf("vec%0d_arrived", i), 64'(got), 64'(1));
         check($sformatf("vec%0d_floor", i), 64'(flr), 64'(vecs[i].floor));
         check($sformatf("vec%0d_wr", i), 64'(wr), 64'(vecs[i].wr));
         check($sformatf("vec%0d_up_cycles", i), 64'(ups), 64'(vecs[i].ups));
         check($sformatf("vec%0d_down_cycles", i), 64'(downs), 64'(vecs[i].downs));
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].ups + vecs[i].downs + 1));
         run_door(dn, idl);
         check($sformatf("vec%0d_door_cycles", i), 64'(dn), 64'(D));
         check($sformatf("vec%0d_idle_after", i), 64'(idl), 64'(1));
         check($sformatf("vec%0d_queue_cleared", i), 64'(qbits), 64'(0));
      end

      // At floor 3 heading up with {1,6}: 6 first, then reverse to 1.
      do_reset();
      qbits = 8'h08; queue_rd = qbits;
      run_stop(200, lat, ups, downs, wr, flr, got);
      check("scan_setup_floor", 64'(flr), 64'(3));
      run_door(dn, idl);
      qbits = 8'h42; queue_rd = qbits;
      run_stop(200, lat, ups, downs, wr, flr, got);
      check("scan_first_wr", 64'(wr), 64'(8'h40));
      check("scan_first_up", 64'(ups), 64'(24));
      run_door(dn, idl);
      check("scan_first_door", 64'(dn), 64'(D));
      run_stop(200, lat, ups, downs, wr, flr, got);
      check("scan_second_wr", 64'(wr), 64'(8'h02));
      check("scan_second_down", 64'(downs), 64'(40));
      check("scan_second_lat", 64'(lat), 64'(41));

      // Same-floor request re-raised halfway through the door dwell.
      dn = 0; done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         step();
         if (door_open) begin
            dn++;
            if (dn == 8) begin
               qbits    = qbits | 8'h02;
               queue_rd = qbits;
            end
         end else begin
            done = 1'b1;
         end
      end
      check("middoor_first_dwell", 64'(dn), 64'(D));
      check("middoor_idle_gap", 64'(idle), 64'(1));
      step();
      check("middoor_rearrive", 64'({queue_r_nwr, queue_clear, queue_wr}), 64'({1'b0, 1'b1, 8'h02}));
      run_door(dn, idl);
      check("middoor_second_dwell", 64'(dn), 64'(D));
      check("middoor_idle_after", 64'(idl), 64'(1));

      // Reset at travel count 4 between floors 2 and 3.
      do_reset();
      qbits = 8'h04; queue_rd = qbits;
      run_stop(200, lat, ups, downs, wr, flr, got);
      run_door(dn, idl);
      qbits = 8'h08; queue_rd = qbits;
      repeat (5) step();
      check("midmove_before", 64'({moving_up, current_floor}), 64'({1'b1, 3'd2}));
      reset = 1'b1; qbits = '0; queue_rd = '0; clr_pend = 1'b0;
      step();
      reset = 1'b0;
      check("midmove_reset",
            64'({current_floor, moving_up, moving_down, door_open, idle, queue_r_nwr}),
            64'({3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}));

      // Random static request sets against a stop-list model.
      do_reset();
      mf = 0; md = 1'b1;
      for (int it = 0; it < 25; it++) begin
         bits = 8'($urandom_range(1, 255));
         exp_cyc.delete(); exp_wr.delete(); exp_fl.delete();
         got_cyc.delete(); got_wr.delete(); got_fl.delete();
         b = bits; t0 = cyc; t = t0; first = 1'b1;
         while (b != 0) begin
            found = b[mf];
            nxt   = mf;
            for (int pass = 0; pass < 2 && !found; pass++) begin
               for (int k = 1; k < 8 && !found; k++) begin
                  j = md ? mf + k : mf - k;
                  if (j >= 0 && j < 8 && b[j]) begin
                     nxt   = j;
                     found = 1'b1;
                  end
               end
               if (!found) md = ~md;
            end
            n = (nxt > mf) ? nxt - mf : mf - nxt;
            t = first ? t + 1 + n * T : t + D + 2 + n * T;
            exp_cyc.push_back(t);
            exp_wr.push_back(8'd1 << nxt);
            exp_fl.push_back(3'(nxt));
            b[nxt] = 1'b0;
            mf     = nxt;
            first  = 1'b0;
         end
         tend = t + D + 1;
         qbits = bits; queue_rd = qbits;
         while (cyc < tend) begin
            step();
            if (!queue_r_nwr) begin
               got_cyc.push_back(cyc - t0);
               got_wr.push_back(queue_wr);
               got_fl.push_back(current_floor);
            end
         end
         check($sformatf("rnd%0d_stops", it), 64'(got_cyc.size()), 64'(exp_cyc.size()));
         for (int k = 0; k < exp_cyc.size() && k < got_cyc.size(); k++) begin
            check($sformatf("rnd%0d_stop%0d_time", it, k), 64'(got_cyc[k]), 64'(exp_cyc[k] - t0));
            check($sformatf("rnd%0d_stop%0d_wr", it, k), 64'(got_wr[k]), 64'(exp_wr[k]));
            check($sformatf("rnd%0d_stop%0d_floor", it, k), 64'(got_fl[k]), 64'(exp_fl[k]));
         end
         check($sformatf("rnd%0d_idle_end", it), 64'(idle), 64'(1));
         check($sformatf("rnd%0d_queue_empty", it), 64'(qbits), 64'(0));
      end

      check("never_both_motors", 64'(both_err), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/elevator_car_controller.md
# elevator_car_controller

Consumes the floor-request bitmap held by the elevator queue and drives a single car. It chooses the next stop with a SCAN (continue-in-direction) policy and times floor-to-floor travel and door dwell. On arrival it issues a one-cycle clear write back to the queue. Sits directly downstream of the queue, between it and the car's motor/door outputs.

## Interface
- FLOOR_COUNT, 8, number of floors; bit i of the bitmap = floor i.
- TRAVEL_CYCLES, 8, clk cycles to move one floor (≥1).
- DOOR_CYCLES, 16, clk cycles door stays open (≥1).
- FW = $clog2(FLOOR_COUNT), derived floor-index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- queue_rd  in  FLOOR_COUNT  current queue contents; valid whenever queue_r_nwr=1.
- queue_r_nwr  out  1  1 = read queue (default), 0 = write this cycle.
- queue_clear  out  1  with queue_r_nwr=0, requests a bit clear.
- queue_wr  out  FLOOR_COUNT  write data; top level drives it onto the queue bus when queue_r_nwr=0.
- current_floor  out  FW  floor the car is at, or last passed.
- moving_up / moving_down  out  1 each  motor commands; never both 1.
- door_open  out  1  door command.
- idle  out  1  1 in IDLE state.

## Operation
- FSM states: IDLE, MOVE, ARRIVE, DOOR. Register dir (1 = up).
- Request classes: here = queue_rd[current_floor]; above = any bit > current_floor; below = any bit < current_floor.
- IDLE, evaluated each cycle:
  - here → ARRIVE.
  - else if a request exists in dir → MOVE in dir.
  - else if a request exists opposite → flip dir, MOVE.
  - else stay in IDLE.
- MOVE: moving_up or moving_down per dir. The travel counter runs 0..TRAVEL_CYCLES-1. On terminal count, current_floor ±1 and the counter clears. Then re-evaluate at the new floor using the IDLE rules, except that the empty case → IDLE.
- ARRIVE: exactly one cycle.
  - queue_r_nwr=0, queue_clear=1, queue_wr = one-hot(current_floor).
  - Always → DOOR.
- DOOR: door_open=1 for DOOR_CYCLES cycles, then → IDLE.
  - A new request for the current floor arriving during DOOR is serviced by IDLE, which re-enters ARRIVE and reopens the door.
- ARRIVE is only entered with the bit set, so the queue's clear is always accepted, never treated as an OR-write.
- Outside ARRIVE: queue_r_nwr=1, queue_clear=0, queue_wr=0.
- Top level gives this block bus priority over call-button writes in the ARRIVE cycle.
- Floor bounds: at floor 0 with dir=0, or at FLOOR_COUNT-1 with dir=1, no request can exist in dir, so the reversal rule applies. current_floor never wraps.
- Direction is retained in IDLE with an empty queue.

## Timing
- Reset values:
  - state=IDLE, current_floor=0, dir=1, counters=0.
  - moving_up=moving_down=door_open=0, idle=1.
  - queue_r_nwr=1, queue_clear=0, queue_wr=0.
- Reset mid-MOVE or mid-DOOR returns to the reset values next edge; the position is not preserved.
- Outputs are registered and decoded from state; decisions use queue_rd sampled on the same edge.
- Request at the current floor while IDLE: ARRIVE 1 cycle after the bit appears; door_open 2 cycles after.
- One-floor trip: TRAVEL_CYCLES cycles in MOVE, then ARRIVE, then DOOR_CYCLES cycles in DOOR.
- The queue updates on the ARRIVE edge, so queue_rd shows the bit cleared from the first DOOR cycle.

## Structure
- Shared elevator package holds:
  - the state enum (IDLE/MOVE/ARRIVE/DOOR);
  - the FLOOR_COUNT default;
  - a function onehot(floor) → FLOOR_COUNT bits.
- One sub-module, elevator_request_scan: combinational here/above/below from queue_rd and current_floor, using masks built from current_floor.
- The controller holds the FSM and both counters.

## Test plan
- Reset, queue_rd=0 for 50 cycles → idle=1, current_floor=0, no motor or door activity, queue_r_nwr=1 throughout.
- From floor 0, queue_rd=8'b0000_1000 → moving_up for 3×8=24 cycles, current_floor=3. Then one cycle with queue_r_nwr=0, queue_clear=1, queue_wr=8'h08. Then door_open for 16 cycles, then idle.
- At floor 3 moving up with bits {1,6} → stops at 6 first, then reverses and stops at 1. ARRIVE writes are 8'h40 then 8'h02.
- Car at floor 7 (dir=1), request bit 0 → dir flips, moving_down, 56 cycles to floor 0. Neither current_floor nor the motor ever exceeds floor 7.
- Request for the current floor asserted mid-DOOR → door closes, one IDLE cycle, ARRIVE again, door reopens for the full 16 cycles.
- reset asserted at travel count 4 between floors 2 and 3 → next cycle current_floor=0, moving_up=0, idle=1.
